// File: rtl/cdc_fifo_src_arbiter_if.sv
// rtl/cdc_fifo_src_arbiter_if.sv - requester/FIFO-source handshake bundle for cdc_fifo_src_arbiter
interface cdc_fifo_src_arbiter_if #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32
);
    localparam int IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

    logic [NumIn*DataWidth-1:0] in_data_i;
    logic [NumIn-1:0]           in_last_i;
    logic [NumIn-1:0]           in_valid_i;
    logic [NumIn-1:0]           in_ready_o;
    logic [DataWidth-1:0]       out_data_o;
    logic [IdxW-1:0]            out_idx_o;
    logic                       out_last_o;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic                       busy_o;

    modport master (
        output in_data_i, in_last_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_idx_o, out_last_o, out_valid_o, busy_o
    );

    modport slave (
        input  in_data_i, in_last_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_idx_o, out_last_o, out_valid_o, busy_o
    );
endinterface

// File: rtl/cdc_fifo_src_arbiter.sv
// rtl/cdc_fifo_src_arbiter.sv - round-robin packet arbiter feeding a CDC FIFO source port
// Optional per-grant beat limit enabled by defining CDC_FIFO_ARB_BURST_LIMIT_EN.
module cdc_fifo_src_arbiter #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter int MaxBurst  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    cdc_fifo_src_arbiter_if.slave io
);
    localparam int IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int BeatW = $clog2(MaxBurst + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

    state_e               r_state, w_state_nxt;
    logic [IdxW-1:0]      r_rr, r_gnt, w_rr_nxt, w_gnt_nxt, w_grant, w_grant_inc;
    logic [BeatW-1:0]     r_beat, w_beat_nxt, w_beat_inc;
    logic [DataWidth-1:0] w_data;
    logic                 w_valid, w_last, w_hs, w_release;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
            r_gnt   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // Locked: the owner keeps the port. Idle: first valid requester at or after r_rr.
    always_comb begin
        logic [IdxW:0] w_sum;
        w_sum   = '0;
        w_grant = r_gnt;
        w_valid = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_valid = io.in_valid_i[r_gnt];
        end else begin
            for (int k = 0; k < NumIn; k++) begin
                w_sum = {1'b0, r_rr} + (IdxW+1)'(k);
                if (w_sum >= (IdxW+1)'(NumIn)) w_sum = w_sum - (IdxW+1)'(NumIn);
                if (!w_valid && io.in_valid_i[w_sum[IdxW-1:0]]) begin
                    w_grant = w_sum[IdxW-1:0];
                    w_valid = 1'b1;
                end
            end
        end
        w_data = '0;
        w_last = 1'b0;
        for (int i = 0; i < NumIn; i++) begin
            if (w_grant == IdxW'(i)) begin
                w_data = io.in_data_i[i*DataWidth +: DataWidth];
                w_last = io.in_last_i[i];
            end
        end
    end

    assign w_hs        = w_valid & io.out_ready_i;
    assign w_grant_inc = (w_grant == IdxW'(NumIn - 1)) ? '0 : w_grant + IdxW'(1);
    assign w_beat_inc  = ((r_state == ST_LOCKED) ? r_beat : '0) + BeatW'(1);

`ifdef CDC_FIFO_ARB_BURST_LIMIT_EN
    assign w_release = w_hs & (w_last | (w_beat_inc == BeatW'(MaxBurst)));
`else
    assign w_release = w_hs & w_last;
`endif

    // A stalled first beat still locks, so the grant cannot move until it is taken.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_gnt_nxt   = r_gnt;
        w_beat_nxt  = r_beat;
        if (w_valid) begin
            if (w_release) begin
                w_state_nxt = ST_IDLE;
                w_rr_nxt    = w_grant_inc;
                w_beat_nxt  = '0;
            end else begin
                w_state_nxt = ST_LOCKED;
                w_gnt_nxt   = w_grant;
                if (w_hs) w_beat_nxt = w_beat_inc;
            end
        end
    end

    always_comb begin
        io.out_valid_o = w_valid;
        io.out_idx_o   = w_grant;
        io.out_data_o  = w_data;
        io.out_last_o  = w_last;
        io.busy_o      = (r_state == ST_LOCKED);
        io.in_ready_o  = '0;
        if (w_valid) io.in_ready_o[w_grant] = io.out_ready_i;
    end

`ifndef SYNTHESIS
    a_no_withdraw: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_valid && !io.out_ready_i) |=> io.in_valid_i[r_gnt]);
`endif
endmodule
